// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU op codes, digit count and the formatter FSM state type.
package calc_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    localparam int NUM_DIGITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SIGN  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } fmt_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more before the next shift.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/alu_result_formatter.sv
// ALU result to sign + two BCD digits, iterative double-dabble behind valid/ready ports.
// Optional macro SIGNED_SUB_EN: treat subtract results as two's complement.
module alu_result_formatter
    import calc_pkg::*;
#(
    parameter int RESULT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [RESULT_W-1:0] in_result,
    input  logic                in_status,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [3:0]          out_tens,
    output logic [3:0]          out_ones,
    output logic                out_flag,
    output logic                out_err
);

    localparam int CNT_W = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
    localparam int SH_W  = NUM_DIGITS * 4 + RESULT_W;

    fmt_state_e state_q, state_d;

    logic [1:0]                  op_q, op_d;
    logic [RESULT_W-1:0]         res_q, res_d;
    logic                        status_q, status_d;
    logic [RESULT_W-1:0]         mag_q, mag_d;
    logic                        neg_q, neg_d;
    logic [NUM_DIGITS-1:0][3:0]  bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0][3:0]  bcd_adj;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [SH_W-1:0]             shift_w;

    logic       sign_q, sign_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       flag_q, flag_d;
    logic       err_q, err_d;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_add3 u_add3 (
                .digit_i (bcd_q[g]),
                .digit_o (bcd_adj[g])
            );
        end
    endgenerate

    assign shift_w = {bcd_adj, mag_q} << 1;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        res_d    = res_q;
        status_d = status_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        flag_d   = flag_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d     = in_op;
                    res_d    = in_result;
                    status_d = in_status;
                    state_d  = ST_SIGN;
                end
            end
            ST_SIGN: begin
                neg_d = 1'b0;
                mag_d = res_q;
`ifdef SIGNED_SUB_EN
                if (op_q == OP_SUB && res_q[RESULT_W-1]) begin
                    neg_d = 1'b1;
                    mag_d = (~res_q) + RESULT_W'(1);
                end
`endif
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                {bcd_d, mag_d} = shift_w;
                cnt_d          = cnt_q + CNT_W'(1);
                // Output word is loaded only here, so it stays frozen through DONE.
                if (cnt_q == CNT_W'(RESULT_W - 1)) begin
                    sign_d  = neg_q;
                    tens_d  = shift_w[RESULT_W + 4 +: 4];
                    ones_d  = shift_w[RESULT_W +: 4];
                    flag_d  = status_q;
                    err_d   = (op_q == OP_NONE);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            res_q    <= '0;
            status_q <= 1'b0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            tens_q   <= '0;
            ones_q   <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            res_q    <= res_d;
            status_q <= status_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign out_sign  = sign_q;
    assign out_tens  = tens_q;
    assign out_ones  = ones_q;
    assign out_flag  = flag_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_alu_result_formatter.sv
// Directed bench for alu_result_formatter: vector table plus reset and backpressure sequences.
module tb_alu_result_formatter;
    import calc_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_result;
    logic         in_status;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [3:0]   out_tens;
    logic [3:0]   out_ones;
    logic         out_flag;
    logic         out_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] res;
        logic         st;
        logic         e_sign;
        logic [3:0]   e_tens;
        logic [3:0]   e_ones;
        logic         e_flag;
        logic         e_err;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    alu_result_formatter #(.RESULT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_result (in_result),
        .in_status (in_status),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_tens  (out_tens),
        .out_ones  (out_ones),
        .out_flag  (out_flag),
        .out_err   (out_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_in_ready"},  int'(in_ready),  0);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_sign"},      int'(out_sign),  0);
        chk({nm, "_tens"},      int'(out_tens),  0);
        chk({nm, "_ones"},      int'(out_ones),  0);
        chk({nm, "_flag"},      int'(out_flag),  0);
        chk({nm, "_err"},       int'(out_err),   0);
    endtask

    // Called at a negedge. Latency counts the accepting edge as edge 1;
    // returns at the negedge where out_valid is first seen, or -1 on timeout.
    task automatic send(input logic [1:0] op, input logic [W-1:0] r, input logic s,
                        input logic rdy, output int lat);
        in_op     = op;
        in_result = r;
        in_status = s;
        in_valid  = 1'b1;
        out_ready = rdy;
        #1 chk("in_ready_pre_accept", int'(in_ready), 1);
        lat = -1;
        for (int e = 1; e <= 20 && lat < 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) lat = e;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        tbl[0] = '{OP_ADD,  4'b0110, 1'b0, 1'b0, 4'd0, 4'd6, 1'b0, 1'b0};
        tbl[1] = '{OP_MUL,  4'b1001, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0};
        tbl[2] = '{OP_MUL,  4'b1111, 1'b1, 1'b0, 4'd1, 4'd5, 1'b1, 1'b0};
`ifdef SIGNED_SUB_EN
        tbl[3] = '{OP_SUB,  4'b1110, 1'b1, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0};
        tbl[4] = '{OP_SUB,  4'b1000, 1'b0, 1'b1, 4'd0, 4'd8, 1'b0, 1'b0};
`else
        tbl[3] = '{OP_SUB,  4'b1110, 1'b1, 1'b0, 4'd1, 4'd4, 1'b1, 1'b0};
        tbl[4] = '{OP_SUB,  4'b1000, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0};
`endif
        tbl[5] = '{OP_NONE, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
        tbl[6] = '{OP_ADD,  4'b0101, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0};
        tbl[7] = '{OP_ADD,  4'b1010, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
        tbl[8] = '{OP_SUB,  4'b0111, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0};
        tbl[9] = '{OP_MUL,  4'b1100, 1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0};
`ifdef SIGNED_SUB_EN
        tbl[10] = '{OP_SUB, 4'b1111, 1'b1, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0};
`else
        tbl[10] = '{OP_SUB, 4'b1111, 1'b1, 1'b0, 4'd1, 4'd5, 1'b1, 1'b0};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_result = '0;
        in_status = 1'b0;
        out_ready = 1'b0;

        // Power-on reset
        @(negedge clk);
        chk_all_zero("por_a");
        @(negedge clk);
        chk_all_zero("por_b");
        rst = 1'b0;
        #1 chk("por_release_in_ready", int'(in_ready), 1);

        // Vector table, out_ready held high ahead of out_valid
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            send(tbl[i].op, tbl[i].res, tbl[i].st, 1'b1, lat);
            chk($sformatf("v%0d_latency", i), lat, W + 2);
            chk($sformatf("v%0d_sign", i), int'(out_sign), int'(tbl[i].e_sign));
            chk($sformatf("v%0d_tens", i), int'(out_tens), int'(tbl[i].e_tens));
            chk($sformatf("v%0d_ones", i), int'(out_ones), int'(tbl[i].e_ones));
            chk($sformatf("v%0d_flag", i), int'(out_flag), int'(tbl[i].e_flag));
            chk($sformatf("v%0d_err", i),  int'(out_err),  int'(tbl[i].e_err));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", i), int'(out_valid), 0);
            chk($sformatf("v%0d_ready_back", i), int'(in_ready), 1);
        end

        // Reset held 2 cycles in the middle of SHIFT
        @(negedge clk);
        in_op     = OP_ADD;
        in_result = 4'b0110;
        in_status = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_shift_in_ready_comb", int'(in_ready), 0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk_all_zero("rst_shift");
        end
        rst = 1'b0;
        #1 chk("rst_shift_release_in_ready", int'(in_ready), 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("rst_shift_word_discarded", seen, 0);

        // Backpressure with a competing input word
        @(negedge clk);
        send(OP_MUL, 4'b1111, 1'b1, 1'b0, lat);
        chk("bp_latency", lat, W + 2);
        for (int c = 0; c < 5; c++) begin
            in_op     = OP_ADD;
            in_result = 4'b0011;
            in_status = 1'b0;
            in_valid  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_valid", c),    int'(out_valid), 1);
            chk($sformatf("bp%0d_in_ready", c), int'(in_ready),  0);
            chk($sformatf("bp%0d_tens", c),     int'(out_tens),  1);
            chk($sformatf("bp%0d_ones", c),     int'(out_ones),  5);
            chk($sformatf("bp%0d_flag", c),     int'(out_flag),  1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("bp_new_word_ignored", seen, 0);
        chk("bp_outputs_held_tens", int'(out_tens), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
